div_share_arb: RTL
==================

// Module: div_share_arb
// PURPOSE
//  Shares one pipelined div_16_8 core (fixed latency, one op/clk) between two requesters.
//  Example pair: the dodge and burn stages of the sketch pipeline when the pixel rate is <= clk/2.
//  Arbitrates valid/ready requests (round-robin or fixed priority) and drives the divider.
//  Tags each issued op; routes each quotient back to the requester that issued it, in issue order.
// PARAMETERS
//  DIV_LATENCY  18  divider cycles, from operand sample edge to m_axis_dout_tdata valid
//  ARB_MODE     0   0 = round-robin, 1 = fixed priority (req0 wins)
//  DVD_W        16  dividend width
//  DVS_W        8   divisor width
//  DOUT_W       24  divider output width ({quotient, fraction})
// PORTS
//  clk            in   1       system clock
//  rst_n          in   1       async active-low reset
//  flush          in   1       sync clear of in-flight tags; pulse on frame vs edge
//  req0_valid     in   1       requester 0 has an operation
//  req0_ready     out  1       requester 0 accepted this cycle
//  req0_dividend  in   DVD_W   requester 0 dividend
//  req0_divisor   in   DVS_W   requester 0 divisor
//  req1_valid     in   1       requester 1 has an operation
//  req1_ready     out  1       requester 1 accepted this cycle
//  req1_dividend  in   DVD_W   requester 1 dividend
//  req1_divisor   in   DVS_W   requester 1 divisor
//  div_valid      out  1       drives s_axis_dividend/divisor_tvalid
//  div_dividend   out  DVD_W   drives s_axis_dividend_tdata
//  div_divisor    out  DVS_W   drives s_axis_divisor_tdata
//  div_dout       in   DOUT_W  m_axis_dout_tdata
//  rsp0_valid     out  1       result for requester 0; 1-cycle pulse, no backpressure
//  rsp0_data      out  DOUT_W  requester 0 result
//  rsp0_dbz       out  1       requester 0 op had divisor == 0
//  rsp1_valid     out  1       result for requester 1; 1-cycle pulse, no backpressure
//  rsp1_data      out  DOUT_W  requester 1 result
//  rsp1_dbz       out  1       requester 1 op had divisor == 0
// BEHAVIOUR
//  - Reset: all outputs 0. div_* 0. Tag pipe empty. RR pointer selects req0 first.
//  - Grant (combinational): reqN_ready = reqN_valid & grant[N]. At most one ready per cycle.
//  - Round-robin: only one valid -> grant it. Both valid -> grant the one not granted last.
//    The pointer updates only on a handshake. Neither requester waits more than one op.
//  - ARB_MODE=1: req0 always wins. req1 may starve; this is the integrator's responsibility.
//  - Issue: at handshake edge T, operands are registered to div_dividend/div_divisor and div_valid=1.
//    With no handshake, div_valid=0 and operands hold their previous values.
//  - Tag pipe: {valid, id, dbz} shifts DIV_LATENCY+1 stages, aligned with the div_dout sample.
//  - Response: rsp{id}_valid/data/dbz registered. Latency = DIV_LATENCY+2 edges after edge T.
//    The other rsp*_valid is 0 and its data holds. Order is preserved per requester.
//  - dbz: divisor==0 is passed to the core unchanged. rspN_dbz=1 and rspN_data=all-ones (saturated).
//  - Throughput: one op/clk total. Back-to-back handshakes give back-to-back rsp pulses.
//  - flush: clears every tag valid at the edge. Results of ops already issued are never returned.
//    flush does not block a handshake in the same cycle; that op is tracked normally.
//    flush does not change the RR pointer.
//  - rst_n mid-operation: async clear of tags, pointer and outputs; in-flight results dropped.
//  - Unsigned arithmetic only; no width growth in the arbiter (pure routing plus registers).
// STRUCTURE
//  - sketch_pkg: DIV_LATENCY, DVD_W, DVS_W, DOUT_W.
//  - sketch_pkg: ARB_RR/ARB_FIXED constants; tag struct {vld, id, dbz}.
//  - Sub-module div_tag_pipe: parameterised shift register with sync flush and async reset.
//  - Top: grant logic, issue registers, response demux. The div_16_8 is instantiated by the parent.
// TESTING  (bench uses a behavioural div model with latency DIV_LATENCY)
//  1) Only req0: 5000/100 -> rsp0_valid exactly 20 clks after accept.
//     rsp0_data[23:8]=50, fraction 0. rsp1_valid never high.
//  2) Both valid continuously, ARB_MODE=0 -> grants alternate 0,1,0,1.
//     Each requester receives exactly half the results, in issue order.
//  3) Both valid, ARB_MODE=1 -> req1_ready stays 0 while req0_valid=1.
//     Drop req0_valid -> req1 is granted next cycle.
//  4) req1 divisor=0, dividend=255 -> rsp1_dbz=1, rsp1_data=24'hFFFFFF, rsp1_valid one pulse.
//  5) Issue 10 ops, assert flush 5 clks later -> no rsp for those 10.
//     An op accepted in the flush cycle returns normally.
//  6) Deassert rst_n mid-stream with 12 ops in flight -> all outputs 0 asynchronously.
//     No stale rsp after release. First new grant goes to req0.

Source files
------------

// File: rtl/div_share_arb_pkg.sv
// Shared constants and types for the two-requester divider arbiter.
// The tag carries just enough to route a quotient back: who issued it and whether it was a divide-by-zero.
package div_share_arb_pkg;

  localparam int DIV_LATENCY = 18;
  localparam int DVD_W       = 16;
  localparam int DVS_W       = 8;
  localparam int DOUT_W      = 24;

  localparam int ARB_RR      = 0;
  localparam int ARB_FIXED   = 1;

  typedef struct packed {
    logic vld;
    logic id;
    logic dbz;
  } tag_t;

endpackage

// File: rtl/div_share_arb_tag_pipe.sv
// Shift register of op tags running alongside the divider pipeline.
// flush drops every valid bit, including the tag entering this edge, but still lets ids/dbz shift.
module div_share_arb_tag_pipe
  import div_share_arb_pkg::*;
#(
  parameter int DEPTH = DIV_LATENCY + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t pipe_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      if (flush_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          pipe_q[i].vld <= 1'b0;
        end
      end
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/div_share_arb.sv
// Shares one pipelined divider between two valid/ready requesters.
// Each issued op is tagged so its result returns to the requester that issued it, in issue order.
module div_share_arb
  import div_share_arb_pkg::*;
#(
  parameter int DIV_LATENCY = div_share_arb_pkg::DIV_LATENCY,
  parameter int ARB_MODE    = ARB_RR,
  parameter int DVD_W       = div_share_arb_pkg::DVD_W,
  parameter int DVS_W       = div_share_arb_pkg::DVS_W,
  parameter int DOUT_W      = div_share_arb_pkg::DOUT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DVD_W-1:0]  req0_dividend,
  input  logic [DVS_W-1:0]  req0_divisor,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DVD_W-1:0]  req1_dividend,
  input  logic [DVS_W-1:0]  req1_divisor,
  output logic              div_valid,
  output logic [DVD_W-1:0]  div_dividend,
  output logic [DVS_W-1:0]  div_divisor,
  input  logic [DOUT_W-1:0] div_dout,
  output logic              rsp0_valid,
  output logic [DOUT_W-1:0] rsp0_data,
  output logic              rsp0_dbz,
  output logic              rsp1_valid,
  output logic [DOUT_W-1:0] rsp1_data,
  output logic              rsp1_dbz
);

  logic              last_q;
  logic              gnt0;
  logic              hs;
  logic [DVD_W-1:0]  sel_dividend;
  logic [DVS_W-1:0]  sel_divisor;
  tag_t              issue_tag_q;
  tag_t              ret_tag;

  logic              div_valid_q;
  logic [DVD_W-1:0]  div_dividend_q;
  logic [DVS_W-1:0]  div_divisor_q;
  logic              rsp0_valid_q;
  logic [DOUT_W-1:0] rsp0_data_q;
  logic              rsp0_dbz_q;
  logic              rsp1_valid_q;
  logic [DOUT_W-1:0] rsp1_data_q;
  logic              rsp1_dbz_q;

  // last_q holds the id of the last granted requester; reset to 1 so req0 goes first.
  always_comb begin
    gnt0 = 1'b1;
    if (ARB_MODE != ARB_FIXED) begin
      gnt0 = !req1_valid || last_q;
    end
  end

  assign req0_ready   = req0_valid && gnt0;
  assign req1_ready   = req1_valid && !req0_ready;
  assign hs           = req0_ready || req1_ready;
  assign sel_dividend = req1_ready ? req1_dividend : req0_dividend;
  assign sel_divisor  = req1_ready ? req1_divisor  : req0_divisor;

  // Issue stage: the tag register sits level with div_valid, so the pipe output
  // lines up with the divider result one cycle before it is registered out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q         <= 1'b1;
      div_valid_q    <= 1'b0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
      issue_tag_q    <= '0;
    end else begin
      div_valid_q <= hs;
      issue_tag_q <= '{vld: hs, id: req1_ready, dbz: (sel_divisor == '0)};
      if (hs) begin
        div_dividend_q <= sel_dividend;
        div_divisor_q  <= sel_divisor;
        last_q         <= req1_ready;
      end
    end
  end

  div_share_arb_tag_pipe #(
    .DEPTH (DIV_LATENCY + 1)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .tag_i   (issue_tag_q),
    .tag_o   (ret_tag)
  );

  // A result arriving on the flush edge belongs to an already-issued op and is dropped too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp0_dbz_q   <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
      rsp1_dbz_q   <= 1'b0;
    end else begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      if (ret_tag.vld && !flush) begin
        if (ret_tag.id) begin
          rsp1_valid_q <= 1'b1;
          rsp1_data_q  <= ret_tag.dbz ? '1 : div_dout;
          rsp1_dbz_q   <= ret_tag.dbz;
        end else begin
          rsp0_valid_q <= 1'b1;
          rsp0_data_q  <= ret_tag.dbz ? '1 : div_dout;
          rsp0_dbz_q   <= ret_tag.dbz;
        end
      end
    end
  end

  assign div_valid    = div_valid_q;
  assign div_dividend = div_dividend_q;
  assign div_divisor  = div_divisor_q;
  assign rsp0_valid   = rsp0_valid_q;
  assign rsp0_data    = rsp0_data_q;
  assign rsp0_dbz     = rsp0_dbz_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rsp1_data    = rsp1_data_q;
  assign rsp1_dbz     = rsp1_dbz_q;

endmodule
